// File: rtl/exu_mul_pipe_if.sv
// Issue/writeback handshake bundle for the EXU multiplier.
// master = issue/writeback side, slave = multiplier.
interface exu_mul_pipe_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 6
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_src0;
    logic [DATA_W-1:0] in_src1;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_op, in_src0, in_src1, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_src0, in_src1, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/exu_mul_pipe.sv
// Stallable in-order LA64 integer multiplier: operand prep in stage 0, product in the
// middle stages, result select into the last stage, which drives the outputs directly.
module exu_mul_pipe #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 6,
    parameter int STAGES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    exu_mul_pipe_if.slave bus
);
    localparam int H  = DATA_W / 2;
    localparam int XW = DATA_W + 1;
    localparam int PW = 2 * DATA_W;

    localparam logic [2:0] OP_MUL_W   = 3'd0;
    localparam logic [2:0] OP_MULH_W  = 3'd1;
    localparam logic [2:0] OP_MULH_WU = 3'd2;
    localparam logic [2:0] OP_MUL_D   = 3'd3;
    localparam logic [2:0] OP_MULH_D  = 3'd4;
    localparam logic [2:0] OP_MULH_DU = 3'd5;

    // Word ops extend from bit H-1; unsigned ops zero-extend so one signed multiply covers all.
    function automatic logic [XW-1:0] ext_operand(input logic [DATA_W-1:0] src,
                                                  input logic [2:0]        op);
        logic word_s;
        logic sgn_s;
        logic [XW-1:0] ext_s;
        word_s = 1'b0;
        sgn_s  = 1'b0;
        case (op)
            OP_MUL_W, OP_MULH_W: begin
                word_s = 1'b1;
                sgn_s  = 1'b1;
            end
            OP_MULH_WU: begin
                word_s = 1'b1;
                sgn_s  = 1'b0;
            end
            OP_MUL_D, OP_MULH_D: begin
                word_s = 1'b0;
                sgn_s  = 1'b1;
            end
            OP_MULH_DU: begin
                word_s = 1'b0;
                sgn_s  = 1'b0;
            end
            default: begin
                word_s = 1'b0;
                sgn_s  = 1'b0;
            end
        endcase
        if (word_s) begin
            ext_s = {{(XW-H){sgn_s & src[H-1]}}, src[H-1:0]};
        end else begin
            ext_s = {sgn_s & src[DATA_W-1], src};
        end
        return ext_s;
    endfunction

    // High-word results are sign-extended even for MULH.WU, matching LA64.
    function automatic logic [DATA_W-1:0] sel_result(input logic [2:0]    op,
                                                     input logic [PW-1:0] prod);
        logic [DATA_W-1:0] res_s;
        case (op)
            OP_MUL_W:               res_s = {{H{prod[H-1]}}, prod[H-1:0]};
            OP_MULH_W, OP_MULH_WU:  res_s = {{H{prod[DATA_W-1]}}, prod[DATA_W-1:H]};
            OP_MUL_D:               res_s = prod[DATA_W-1:0];
            OP_MULH_D, OP_MULH_DU:  res_s = prod[PW-1:DATA_W];
            default:                res_s = '0;
        endcase
        return res_s;
    endfunction

    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] room_s;
    logic [STAGES-1:0] load_s;
    logic              accept_s;
    logic [XW-1:0]     a_r;
    logic [XW-1:0]     b_r;
    logic [2:0]        op_r  [STAGES-1];
    logic [TAG_W-1:0]  tag_r [STAGES];
    logic [DATA_W-1:0] res_r;
    logic [PW-1:0]     prod_s;
    logic [PW-1:0]     prod_last_s;

    // A stage advances when it is full and some stage above it, or the consumer, has room.
    always_comb begin
        room_s = '0;
        adv_s  = '0;
        for (int s = 0; s < STAGES; s++) begin
            room_s[s] = bus.out_ready;
            for (int k = s + 1; k < STAGES; k++) begin
                room_s[s] = room_s[s] | ~v_r[k];
            end
            adv_s[s] = v_r[s] & room_s[s];
        end
    end

    assign load_s       = ~v_r | adv_s;
    assign bus.in_ready = ~bus.flush & load_s[0];
    assign accept_s     = bus.in_valid & bus.in_ready;

    // Stage valid bits; flush wins over every load, including a stage-0 accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r <= '0;
        end else if (bus.flush) begin
            v_r <= '0;
        end else begin
            if (load_s[0]) begin
                v_r[0] <= bus.in_valid;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (load_s[s]) begin
                    v_r[s] <= adv_s[s-1];
                end
            end
        end
    end

    // Sign/zero-extended operands widened to PW: the low PW bits of this product equal
    // the low PW bits of the (DATA_W+1)-bit signed product.
    assign prod_s = {{(PW-XW){a_r[XW-1]}}, a_r} * {{(PW-XW){b_r[XW-1]}}, b_r};

    generate
        if (STAGES > 2) begin : g_prod_pipe
            logic [PW-1:0] prod_r [STAGES-2];

            // Product registers for stages 1..STAGES-2, giving retiming room for the multiply.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < STAGES - 2; j++) begin
                        prod_r[j] <= '0;
                    end
                end else begin
                    if (adv_s[0]) begin
                        prod_r[0] <= prod_s;
                    end
                    for (int j = 1; j < STAGES - 2; j++) begin
                        if (adv_s[j]) begin
                            prod_r[j] <= prod_r[j-1];
                        end
                    end
                end
            end

            assign prod_last_s = prod_r[STAGES-3];
        end else begin : g_prod_comb
            assign prod_last_s = prod_s;
        end
    endgenerate

    // Operand, op, tag and result registers; each only moves on a real transfer into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
            for (int s = 0; s < STAGES - 1; s++) begin
                op_r[s] <= '0;
            end
            for (int s = 0; s < STAGES; s++) begin
                tag_r[s] <= '0;
            end
        end else begin
            if (accept_s) begin
                a_r      <= ext_operand(bus.in_src0, bus.in_op);
                b_r      <= ext_operand(bus.in_src1, bus.in_op);
                op_r[0]  <= bus.in_op;
                tag_r[0] <= bus.in_tag;
            end
            for (int s = 1; s < STAGES - 1; s++) begin
                if (adv_s[s-1]) begin
                    op_r[s] <= op_r[s-1];
                end
            end
            for (int s = 1; s < STAGES; s++) begin
                if (adv_s[s-1]) begin
                    tag_r[s] <= tag_r[s-1];
                end
            end
            if (adv_s[STAGES-2]) begin
                res_r <= sel_result(op_r[STAGES-2], prod_last_s);
            end
        end
    end

    assign bus.out_valid  = v_r[STAGES-1];
    assign bus.out_result = res_r;
    assign bus.out_tag    = tag_r[STAGES-1];
endmodule

// File: tb/tb_exu_mul_pipe.sv
// Scoreboard bench for exu_mul_pipe: stimulus pushes expected results, a negedge monitor
// pops and compares them whenever a result is handed over.
module tb_exu_mul_pipe;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 6;
    localparam int STAGES = 3;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  tag;
        logic [63:0] exp;
        bit          chk_lat;
    } req_t;

    typedef struct {
        logic [63:0] exp;
        logic [5:0]  tag;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_acc   = 0;
    req_t        req_q[$];
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic        held_v = 1'b0;
    logic [63:0] held_res;
    logic [5:0]  held_tag;

    exu_mul_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    exu_mul_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] tag, input logic [63:0] exp, input bit lat);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.tag = tag; r.exp = exp; r.chk_lat = lat;
        req_q.push_back(r);
    endtask

    // One cycle of stimulus: inputs change just after the rising edge.
    task automatic step(input logic ordy, input logic fl);
        exp_t e;
        @(posedge clk);
        #1;
        bus.out_ready = ordy;
        bus.flush     = fl;
        if (req_q.size() != 0) begin
            bus.in_valid = 1'b1;
            bus.in_op    = req_q[0].op;
            bus.in_src0  = req_q[0].a;
            bus.in_src1  = req_q[0].b;
            bus.in_tag   = req_q[0].tag;
        end else begin
            bus.in_valid = 1'b0;
        end
        #1;
        if (fl) begin
            check("flush_in_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
            #1;
            sb_q.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            e.exp = req_q[0].exp; e.tag = req_q[0].tag;
            e.acc_cyc = cyc; e.chk_lat = req_q[0].chk_lat;
            sb_q.push_back(e);
            void'(req_q.pop_front());
            n_acc++;
        end
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((req_q.size() != 0 || sb_q.size() != 0) && k < limit) begin
            step(1'b1, 1'b0);
            k++;
        end
        n_tests++;
        if (req_q.size() != 0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d requests and %0d results still outstanding after %0d cycles",
                     req_q.size(), sb_q.size(), limit);
        end
    endtask

    // Monitor: hold stability under backpressure, and in-order result/tag/latency checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_result", bus.out_result, held_res);
                check("hold_tag", 64'(bus.out_tag), 64'(held_tag));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: tag %0d result 0x%h with nothing outstanding",
                             bus.out_tag, bus.out_result);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("result", bus.out_result, mon_e.exp);
                    check("tag", 64'(bus.out_tag), 64'(mon_e.tag));
                    if (mon_e.chk_lat) begin
                        check("latency", 64'(cyc - mon_e.acc_cyc), 64'(STAGES));
                    end
                end
            end
            held_v   = bus.out_valid & ~bus.out_ready & ~bus.flush;
            held_res = bus.out_result;
            held_tag = bus.out_tag;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_src0   = 64'd0;
        bus.in_src1   = 64'd0;
        bus.in_tag    = 6'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_result", bus.out_result, 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        #3 rst_n = 1'b1;
        #1 check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed op vectors, back to back
        add(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd5,  64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        add(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd6,  64'h0000_0000_0000_0001, 1'b1);
        add(3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd7,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        add(3'd2, 64'h1234_5678_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 6'd8,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        add(3'd1, 64'h1234_5678_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 6'd9,
            64'h0000_0000_0000_0000, 1'b1);
        add(3'd0, 64'h0000_0000_7FFF_FFFF, 64'd2, 6'd10, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        add(3'd0, 64'hDEAD_BEEF_0000_0003, 64'hCAFE_BABE_FFFF_FFFE, 6'd11,
            64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        add(3'd3, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 6'd12, 64'd0, 1'b1);
        add(3'd5, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 6'd13, 64'd1, 1'b1);
        add(3'd4, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd14,
            64'h4000_0000_0000_0000, 1'b1);
        add(3'd6, 64'd1234, 64'd5678, 6'd15, 64'd0, 1'b1);
        add(3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd16, 64'd0, 1'b1);
        drain(60);

        // 8-op stream, tags 0..7, consumer always ready
        for (int i = 0; i < 8; i++) begin
            add(3'd3, 64'(i + 1), 64'd16, 6'(i), 64'((i + 1) * 16), 1'b1);
        end
        drain(40);

        // Backpressure: consumer stalls for 6 cycles from an empty pipe
        for (int i = 0; i < 5; i++) begin
            add(3'd3, 64'(i + 100), 64'd3, 6'(20 + i), 64'((i + 100) * 3), 1'b0);
        end
        n_acc = 0;
        repeat (6) step(1'b0, 1'b0);
        check("bp_accepts", 64'(n_acc), 64'd3);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        drain(40);

        // Flush with three ops in flight and a fourth waiting at the input
        add(3'd3, 64'd7,  64'd9,  6'd30, 64'd63,  1'b1);
        add(3'd3, 64'd8,  64'd9,  6'd31, 64'd72,  1'b1);
        add(3'd3, 64'd10, 64'd9,  6'd32, 64'd90,  1'b1);
        add(3'd3, 64'd11, 64'd11, 6'd33, 64'd121, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        drain(40);

        // Asynchronous reset with results held at the output
        add(3'd3, 64'd2, 64'd3, 6'd40, 64'd6,  1'b0);
        add(3'd3, 64'd4, 64'd3, 6'd41, 64'd12, 1'b0);
        add(3'd3, 64'd5, 64'd3, 6'd42, 64'd15, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        #1 check("rst_pre_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_out_result", bus.out_result, 64'd0);
        check("rst_mid_out_tag", 64'(bus.out_tag), 64'd0);
        sb_q.delete();
        req_q.delete();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        #1 check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        add(3'd0, 64'h0000_0000_FFFF_FFFD, 64'd7, 6'd50, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/exu_mul_pipe.md
Name: exu_mul_pipe

Overview:
- Parametrised, stallable, pipelined integer multiplier for the EXU.
- Covers all LA64 multiply ops: MUL.W, MULH.W, MULH.WU, MUL.D, MULH.D, MULH.DU.
- Adds a valid/ready handshake on both sides, per-instruction tag passthrough, pipeline flush and configurable depth.
- Sits between issue and writeback alongside the ALU.

Parameters:
- DATA_W, 64, operand/result width; must be even; word ops use the low DATA_W/2 bits.
- TAG_W, 6, width of the opaque tag (ROB/dest id) carried with each op.
- STAGES, 3, pipeline depth in register stages; legal range 2..6.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept the request this cycle
- in_op  in  3  0 MUL.W, 1 MULH.W, 2 MULH.WU, 3 MUL.D, 4 MULH.D, 5 MULH.DU, 6/7 reserved
- in_src0  in  DATA_W  multiplicand
- in_src1  in  DATA_W  multiplier
- in_tag  in  TAG_W  tag returned with the result
- flush  in  1  kill all in-flight ops
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_result  out  DATA_W  result
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rst_n.
- Reset values: all stage valid bits 0, out_valid=0, out_result=0, out_tag=0, in_ready=1 once reset deasserts.
- Stage s holds v[s] plus op/tag/data. Stage STAGES-1 drives the outputs directly from registers.
- Advance rule: adv[s] = v[s] & (s==STAGES-1 ? out_ready : !v[s+1] | adv[s+1]).
- A stage loads when it is empty or advancing. No bubbles are inserted under backpressure.
- Accept: in_ready = !flush & (!v[0] | adv[0]). A transfer happens when in_valid & in_ready.
- Latency: an accepted op appears on out_valid exactly STAGES cycles after the accept edge when out_ready is held 1.
- Throughput: 1 op/cycle.
- Ordering: strictly in order. Tags are never reordered.
- Backpressure: with out_ready=0, out_valid, out_result and out_tag hold stable. The pipeline fills, then in_ready drops. It never overwrites an unconsumed result.
- Stage 0 (operand prep):
  - H = DATA_W/2.
  - W ops use src[H-1:0]; D ops use the full DATA_W.
  - Signed ops (0, 1, 3, 4): each operand is sign-extended to DATA_W+1 bits.
  - Unsigned ops (2, 5): each operand is zero-extended to DATA_W+1 bits.
  - For W ops the extension is from bit H-1.
- Multiply: a (DATA_W+1)x(DATA_W+1) signed product. It may be split across stages 1..STAGES-2 (partial products, then sum) or left to retiming. Only the low 2*DATA_W bits are kept.
- Result select in the last stage:
  - MUL.W: sext(prod[H-1:0]).
  - MULH.W / MULH.WU: sext(prod[2H-1:H]); LA64 sign-extends the unsigned high word too.
  - MUL.D: prod[DATA_W-1:0].
  - MULH.D / MULH.DU: prod[2*DATA_W-1:DATA_W].
  - Reserved ops: result 0, still returned with their tag.
- Flush: when flush=1 at an edge, all v[s] clear at that edge, including a stage 0 load that would otherwise occur; in_ready=0 that cycle. out_valid is 0 the cycle after flush. Data registers need not clear.
- Simultaneous out_ready=1 and flush=1: the result presented in that cycle counts as consumed. Everything behind it is killed.
- Reset mid-operation: all valid bits clear asynchronously. No output is produced for ops in flight.

Test Plan:
- MUL.D src0=0xFFFFFFFF_FFFFFFFF, src1=2, tag=5 -> after 3 cycles out_valid=1, result=0xFFFFFFFF_FFFFFFFE, tag=5.
- MULH.DU same operands -> 0x00000000_00000001. MULH.D same operands -> 0xFFFFFFFF_FFFFFFFF.
- MULH.WU src0=0x12345678_FFFFFFFF, src1=0xFFFFFFFF -> 0xFFFFFFFF_FFFFFFFE. MULH.W same operands -> 0. MUL.W 0x7FFFFFFF*2 -> 0xFFFFFFFF_FFFFFFFE.
- Back-to-back stream of 8 ops with tags 0..7 and out_ready=1 -> 8 consecutive results, tags 0..7 in order, first result 3 cycles after the first accept.
- out_ready=0 for 6 cycles during the stream -> in_ready drops after 3 accepts, outputs stay stable, no loss or duplication after release.
- flush asserted with 3 ops in flight plus in_valid=1 -> in_ready=0 that cycle, no out_valid for the killed tags, next accepted op returns normally. rst_n pulsed low mid-stream -> out_valid=0 and out_result=0 immediately.
